// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage between the synchronous-read ROM and decode.
// Owns the PC, absorbs the ROM's one-cycle read latency and buffers up to two
// fetched words in a skid FIFO so decode can stall without losing anything.
// A redirect flushes all fetched work and restarts fetch at the new target.
module ifetch_unit #(
    parameter int                  ADDR_WIDTH = 7,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0]         NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [31:0]           out_instr,
    output logic                  misaligned_err
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PC_WIDTH-1:0] fifo_pc_q [0:1];
    logic [PC_WIDTH-1:0] fifo_pc_d [0:1];
    logic [31:0]         fifo_instr_q [0:1];
    logic [31:0]         fifo_instr_d [0:1];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                misaligned_q, misaligned_d;

    logic                pop;
    logic                issue;
    logic [2:0]          occupancy;

    assign imem_addr      = pc_q[ADDR_WIDTH+1:2];
    assign misaligned_err = misaligned_q;

    // Present the FIFO head to decode, or a NOP bubble when nothing is buffered.
    always_comb begin
        out_valid = (count_q != 2'd0);
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = fifo_pc_q[rd_ptr_q];
            out_instr = fifo_instr_q[rd_ptr_q];
        end
    end

    // Credit check: only issue when buffered-after-pop plus in-flight leaves a free slot.
    always_comb begin
        pop       = out_valid && out_ready;
        occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
        issue     = fetch_en && !redirect_valid && (occupancy < 3'd2);
    end

    // Next-state: redirect flushes everything, otherwise issue/push/pop the pipeline.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        misaligned_d  = misaligned_q;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[PC_WIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + PC_WIDTH'(4);
            end
            if (inflight_q) begin
                fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_instr;
                wr_ptr_d               = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    // State registers with synchronous reset back to the reset PC and an empty pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_pc_q   <= '0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            misaligned_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_pc_q   <= inflight_pc_d;
            fifo_pc_q       <= fifo_pc_d;
            fifo_instr_q    <= fifo_instr_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            misaligned_q    <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with a synchronous ROM model,
// a transaction-level reference model checked every cycle, and literal
// expectations for the key scenarios.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [6:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misaligned_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [0:127];

    ifetch_unit #(
        .ADDR_WIDTH(7),
        .PC_WIDTH  (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM, output forced to zero while in reset.
    always @(posedge clk) begin
        imem_instr <= rst ? 32'h0 : rom[imem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expectOut(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, " out_pc"}, out_pc, pc);
        checkOutput({tag, " out_instr"}, out_instr, instr);
    endtask

    task automatic applyStimulus(input logic r, input logic fe, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    // Reference model: a queue of outstanding fetches (issued, not yet taken by decode).
    // A fetch becomes visible two cycles after it is issued, and at most two may be outstanding.
    typedef struct {
        logic [31:0] pc;
        int          t_issue;
    } req_t;

    req_t        pend[$];
    logic [31:0] m_pc  = 32'h0;
    logic        m_err = 1'b0;
    bit          model_ok = 1'b0;
    int          now = 0;

    // Compare DUT against the model mid-cycle, then advance the model by one clock.
    always @(negedge clk) begin : model_proc
        logic        m_valid;
        logic [31:0] m_opc;
        logic [31:0] m_oinstr;
        req_t        head;

        m_valid  = 1'b0;
        m_opc    = 32'h0;
        m_oinstr = NOP;
        if (pend.size() > 0) begin
            head = pend[0];
            if (now >= head.t_issue + 2) begin
                m_valid  = 1'b1;
                m_opc    = head.pc;
                m_oinstr = rom[head.pc[8:2]];
            end
        end

        if (model_ok) begin
            checkOutput($sformatf("model out_valid @%0d", now), 32'(out_valid), 32'(m_valid));
            checkOutput($sformatf("model out_pc @%0d", now), out_pc, m_opc);
            checkOutput($sformatf("model out_instr @%0d", now), out_instr, m_oinstr);
            checkOutput($sformatf("model imem_addr @%0d", now), 32'(imem_addr), 32'(m_pc[8:2]));
            checkOutput($sformatf("model misaligned_err @%0d", now), 32'(misaligned_err), 32'(m_err));
        end

        if (rst) begin
            pend.delete();
            m_pc     = 32'h0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else if (redirect_valid) begin
            pend.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                m_err = 1'b1;
            end
        end else begin
            if (m_valid && out_ready) begin
                void'(pend.pop_front());
            end
            if (fetch_en && pend.size() < 2) begin
                pend.push_back('{m_pc, now});
                m_pc = m_pc + 32'd4;
            end
        end
        now++;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence with hand-computed literal expectations.
    initial begin
        logic [15:0] ready_pat;

        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        for (int i = 0; i < 128; i++) begin
            rom[i] = 32'hA5A5_0000 | 32'(i);
        end
        rom[0]   = 32'hfe01_0113;
        rom[1]   = 32'h0011_2e23;
        rom[2]   = 32'h0081_2c23;
        rom[3]   = 32'h0201_0413;
        rom[4]   = 32'hfea4_2623;
        rom[28]  = 32'hfe01_0113;
        rom[29]  = 32'h0011_2e23;
        rom[30]  = 32'h0081_2c23;
        rom[127] = 32'h0000_0013;

        repeat (3) applyStimulus(1, 1, 0, 32'h0, 1);
        expectOut("reset", 0, 32'h0, NOP);
        checkOutput("reset imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("reset misaligned_err", 32'(misaligned_err), 32'h0);

        // Reset release and first fetches.
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("t0", 0, 32'h0, NOP);
        checkOutput("t0 imem_addr", 32'(imem_addr), 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("t0+1", 0, 32'h0, NOP);
        checkOutput("t0+1 imem_addr", 32'(imem_addr), 32'h1);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("t0+2", 1, 32'h0, 32'hfe01_0113);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("t0+3", 1, 32'h4, 32'h0011_2e23);

        // Decode stall for five cycles with 0x8 at the head.
        applyStimulus(0, 1, 0, 32'h0, 0);
        expectOut("stall0", 1, 32'h8, 32'h0081_2c23);
        checkOutput("stall0 imem_addr", 32'(imem_addr), 32'h4);
        for (int k = 1; k < 5; k++) begin
            applyStimulus(0, 1, 0, 32'h0, 0);
            expectOut($sformatf("stall%0d", k), 1, 32'h8, 32'h0081_2c23);
            checkOutput($sformatf("stall%0d imem_addr", k), 32'(imem_addr), 32'h4);
        end
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("release", 1, 32'h8, 32'h0081_2c23);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("release+1", 1, 32'hC, 32'h0201_0413);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("release+2", 1, 32'h10, 32'hfea4_2623);

        // Redirect to 0x70 while the stream is running.
        applyStimulus(0, 1, 1, 32'h70, 1);
        expectOut("redir r", 1, 32'h14, 32'hA5A5_0005);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("redir r+1", 0, 32'h0, NOP);
        checkOutput("redir r+1 imem_addr", 32'(imem_addr), 32'h1C);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("redir r+2", 0, 32'h0, NOP);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("redir r+3", 1, 32'h70, 32'hfe01_0113);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("redir r+4", 1, 32'h74, 32'h0011_2e23);

        // Fill the FIFO with decode stalled, then redirect.
        applyStimulus(0, 1, 0, 32'h0, 0);
        expectOut("full a", 1, 32'h78, 32'h0081_2c23);
        applyStimulus(0, 1, 0, 32'h0, 0);
        applyStimulus(0, 1, 1, 32'h70, 0);
        expectOut("full r", 1, 32'h78, 32'h0081_2c23);
        applyStimulus(0, 1, 0, 32'h0, 0);
        expectOut("full r+1", 0, 32'h0, NOP);
        applyStimulus(0, 1, 0, 32'h0, 0);
        expectOut("full r+2", 0, 32'h0, NOP);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("full r+3", 1, 32'h70, 32'hfe01_0113);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("full r+4", 1, 32'h74, 32'h0011_2e23);

        // Misaligned redirect target sets the sticky flag.
        applyStimulus(0, 1, 1, 32'h72, 1);
        checkOutput("mis r err", 32'(misaligned_err), 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkOutput("mis r+1 err", 32'(misaligned_err), 32'h1);
        expectOut("mis r+1", 0, 32'h0, NOP);
        applyStimulus(0, 1, 0, 32'h0, 1);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("mis r+3", 1, 32'h70, 32'hfe01_0113);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkOutput("mis r+4 err", 32'(misaligned_err), 32'h1);

        // Redirect near the top of the ROM: address wraps, full PC keeps counting.
        applyStimulus(0, 1, 1, 32'h1FC, 1);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkOutput("wrap r+1 imem_addr", 32'(imem_addr), 32'd127);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkOutput("wrap r+2 imem_addr", 32'(imem_addr), 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("wrap r+3", 1, 32'h1FC, 32'h0000_0013);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("wrap r+4", 1, 32'h200, 32'hfe01_0113);
        checkOutput("wrap err", 32'(misaligned_err), 32'h1);

        // Reset mid-stream together with a misaligned redirect: reset wins.
        applyStimulus(1, 1, 1, 32'h72, 1);
        expectOut("rst x", 1, 32'h204, 32'h0011_2e23);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("rst x+1", 0, 32'h0, NOP);
        checkOutput("rst x+1 imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("rst x+1 err", 32'(misaligned_err), 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("rst x+2", 0, 32'h0, NOP);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("rst x+3", 1, 32'h0, 32'hfe01_0113);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("rst x+4", 1, 32'h4, 32'h0011_2e23);

        // fetch_en low: in-flight word still delivered, then the stream dries up.
        applyStimulus(0, 0, 0, 32'h0, 1);
        expectOut("fen f", 1, 32'h8, 32'h0081_2c23);
        applyStimulus(0, 0, 0, 32'h0, 1);
        expectOut("fen f+1", 1, 32'hC, 32'h0201_0413);
        checkOutput("fen f+1 imem_addr", 32'(imem_addr), 32'h4);
        applyStimulus(0, 0, 0, 32'h0, 1);
        expectOut("fen f+2", 0, 32'h0, NOP);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("fen f+3", 0, 32'h0, NOP);
        checkOutput("fen f+3 imem_addr", 32'(imem_addr), 32'h4);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkOutput("fen f+4 imem_addr", 32'(imem_addr), 32'h5);
        applyStimulus(0, 1, 0, 32'h0, 1);
        expectOut("fen f+5", 1, 32'h10, 32'hfea4_2623);

        // Irregular decode backpressure, checked by the model only.
        ready_pat = 16'b1011_0010_1110_0101;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 1, 0, 32'h0, ready_pat[k]);
        end
        repeat (4) applyStimulus(0, 1, 0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage sitting directly upstream of the synchronous-read instruction ROM and downstream-facing to decode. Owns the program counter, issues one word address per cycle to the ROM, absorbs the ROM's one-cycle registered read latency, and presents `{pc, instr}` to decode over a valid/ready handshake. A 2-entry skid FIFO lets decode stall without losing fetched words. Taken branches/jumps arrive as a redirect that flushes all fetched work.

## Interface
- `ADDR_WIDTH`, 7: ROM word-address width (ROM depth = 2^ADDR_WIDTH words).
- `PC_WIDTH`, 32: program counter width.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `NOP_INSTR`, 32'h0000_0013: value driven on `out_instr` when `out_valid`=0.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_en`  in  1  when 0, no new ROM requests are issued; in-flight data still completes.
- `redirect_valid`  in  1  redirect request from execute (taken branch, JAL, JALR).
- `redirect_pc`  in  PC_WIDTH  redirect target byte address.
- `imem_addr`  out  ADDR_WIDTH  ROM word address = `pc_q[ADDR_WIDTH+1:2]`.
- `imem_instr`  in  32  ROM data; holds the word addressed in the previous cycle.
- `out_valid`  out  1  fetched instruction available.
- `out_ready`  in  1  decode accepts; transfer when `out_valid && out_ready`.
- `out_pc`  out  PC_WIDTH  byte PC of `out_instr`.
- `out_instr`  out  32  fetched instruction.
- `misaligned_err`  out  1  sticky: a redirect target had `[1:0]` ≠ 0.

## Operation
- State: `pc_q` (address currently driven), `inflight_q` + `inflight_pc_q` (request issued last cycle), 2-entry FIFO of `{pc, instr}`, `count` 0..2.
- `pop` = `out_valid && out_ready`. `issue` = `fetch_en && !redirect_valid && (count - pop + inflight_q) < 2`.
- On `issue`: `inflight_q`←1, `inflight_pc_q`←`pc_q`, `pc_q`←`pc_q + 4` (PC_WIDTH modulo). Else `inflight_q`←0, `pc_q` holds.
- When `inflight_q`=1: push `{inflight_pc_q, imem_instr}` into FIFO (never overflows by credit rule). Push and pop in the same cycle allowed.
- Output: FIFO head when `count` > 0; else `out_valid`=0, `out_instr`=NOP_INSTR, `out_pc`=0.
- Redirect (highest priority below `rst`): FIFO emptied, `inflight_q`←0, `pc_q`←`{redirect_pc[PC_WIDTH-1:2], 2'b00}`, no issue that cycle. A handshake in the redirect cycle counts as accepted. If `redirect_pc[1:0]` ≠ 0, `misaligned_err`←1 (cleared only by `rst`).
- Address wrap: PC bits above `ADDR_WIDTH+1` are ignored for `imem_addr` (aliasing); `out_pc` carries full PC.
- ROM output during/just after reset (zero) is never captured: `inflight_q` is 0 then.
- `fetch_en` low: in-flight word still pushed; FIFO still drains.

## Timing
- Reset values: `pc_q`=RESET_PC, `imem_addr`=RESET_PC word index, `inflight_q`=0, `count`=0, `out_valid`=0, `out_instr`=NOP_INSTR, `out_pc`=0, `misaligned_err`=0.
- Issue at cycle t → `imem_instr` valid t+1 → `out_valid` at t+2 (latency 2).
- First cycle with `rst` low = t0 issue of RESET_PC; first `out_valid` at t0+2.
- Throughput 1 instr/cycle with `out_ready` held high (steady state `count`=1, `inflight_q`=1).
- Redirect in cycle r: target issued r+1, `out_valid` with target at r+3; nothing from old stream visible from r+1 on.
- Stall: at most 2 words buffered; issuing stops when FIFO + in-flight = 2; no word lost or duplicated.
- `rst` mid-operation overrides redirect and handshake; state returns to reset values next cycle.

## Test plan
- Reset release, `out_ready`=1, GCD program loaded: `out_valid` at t0+2, then pc 0x0/fe010113, 0x4/00112e23, 0x8/00812c23 on consecutive cycles.
- Hold `out_ready`=0 for 5 cycles while pc 0x8 at head: outputs frozen at 0x8/00812c23, `imem_addr` stops advancing; on release, 0x8 then 0xC/02010413, 0x10/fea42623 with no gaps or duplicates.
- Redirect to 0x70 in cycle r (stream running): `out_valid`=0 for r+1..r+2, r+3 shows 0x70/fe010113, r+4 0x74/00112e23.
- Redirect while FIFO full and `out_ready`=0: FIFO flushed, `out_valid`=0 next cycle, 0x70 appears at r+3 once ready.
- Redirect to 0x72: `misaligned_err`=1 and stays 1; fetch resumes at 0x70/fe010113; only `rst` clears the flag.
- Redirect to 0x1FC: 0x1FC/00000013 then 0x200/fe010113 (`imem_addr` wraps to 0); assert `rst` mid-stream → `out_valid`=0 next cycle, restart from RESET_PC.
